// File: rtl/decode_hazard_controller_if.sv
// Decode-stage hazard controller bus: decoded operand fields, completion
// handshakes and writeback in; pipeline control and debug state out.
interface decode_hazard_controller_if #(
    parameter int R  = 32,
    parameter int AW = 5,
    parameter int CW = 8
);
    logic          issue_valid_i;
    logic [AW-1:0] A1_i;
    logic [AW-1:0] A2_i;
    logic [AW-1:0] A3_i;
    logic          uses_A1_i;
    logic          uses_A2_i;
    logic          writes_A3_i;
    logic          multicycle_i;
    logic          mem_op_i;
    logic          Exe_Finished_i;
    logic          Mem_Finished_i;
    logic          WB_WE_i;
    logic [AW-1:0] WB_A3_i;
    logic          stall_IF_o;
    logic          enable_ID_EX_o;
    logic          bubble_o;
    logic          issue_o;
    logic [1:0]    state_o;
    logic [R-1:0]  pending_o;
    logic [CW-1:0] wait_cycles_o;

    modport master (
        output issue_valid_i, A1_i, A2_i, A3_i, uses_A1_i, uses_A2_i,
               writes_A3_i, multicycle_i, mem_op_i, Exe_Finished_i,
               Mem_Finished_i, WB_WE_i, WB_A3_i,
        input  stall_IF_o, enable_ID_EX_o, bubble_o, issue_o, state_o,
               pending_o, wait_cycles_o
    );

    modport slave (
        input  issue_valid_i, A1_i, A2_i, A3_i, uses_A1_i, uses_A2_i,
               writes_A3_i, multicycle_i, mem_op_i, Exe_Finished_i,
               Mem_Finished_i, WB_WE_i, WB_A3_i,
        output stall_IF_o, enable_ID_EX_o, bubble_o, issue_o, state_o,
               pending_o, wait_cycles_o
    );
endinterface

// File: rtl/decode_hazard_controller.sv
// Decode-stage sequencer: register scoreboard for RAW/WAW blocking plus a
// wait FSM that holds the pipe across multi-cycle execute/memory operations.
module decode_hazard_controller #(
    parameter int R  = 32,
    parameter int AW = 5,
    parameter int CW = 8
) (
    input  logic CLK,
    input  logic RST,
    decode_hazard_controller_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HAZARD   = 2'd1,
        ST_WAIT_EXE = 2'd2,
        ST_WAIT_MEM = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [R-1:0]  r_pending;
    logic [R-1:0]  w_pending_next;
    logic [R-1:0]  w_set_mask;
    logic [R-1:0]  w_clr_mask;
    logic [CW-1:0] r_wait;
    logic [CW-1:0] w_wait_next;
    logic          r_mem_flag;
    logic          w_hazard;
    logic          w_stall;
    logic          w_enable;
    logic          w_bubble;
    logic          w_issue;

    // Handshake: issue_valid_i marks a decoded instruction in ID; it is
    // consumed only in a cycle where issue_o is high, otherwise ID holds it.
    assign w_hazard = bus.issue_valid_i &
                      ((bus.uses_A1_i   & r_pending[bus.A1_i]) |
                       (bus.uses_A2_i   & r_pending[bus.A2_i]) |
                       (bus.writes_A3_i & r_pending[bus.A3_i]));

    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        w_enable     = 1'b1;
        w_bubble     = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            ST_RUN, ST_HAZARD: begin
                if (w_hazard) begin
                    w_stall      = 1'b1;
                    w_bubble     = 1'b1;
                    w_next_state = ST_HAZARD;
                end else if (bus.issue_valid_i) begin
                    w_issue = 1'b1;
                    if (bus.multicycle_i)
                        w_next_state = ST_WAIT_EXE;
                    else if (bus.mem_op_i)
                        w_next_state = ST_WAIT_MEM;
                    else
                        w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_WAIT_EXE: begin
                // EX keeps its operands while the vector unit finishes
                w_stall  = 1'b1;
                w_enable = 1'b0;
                if (bus.Exe_Finished_i) begin
                    if (r_mem_flag && !bus.Mem_Finished_i)
                        w_next_state = ST_WAIT_MEM;
                    else
                        w_next_state = ST_RUN;
                end
            end
            ST_WAIT_MEM: begin
                w_stall  = 1'b1;
                w_bubble = 1'b1;
                if (bus.Mem_Finished_i)
                    w_next_state = ST_RUN;
            end
            default: w_next_state = ST_RUN;
        endcase
    end

    // Set wins over a same-cycle writeback clear of the same register
    assign w_set_mask     = (w_issue && bus.writes_A3_i) ? (R'(1) << bus.A3_i) : '0;
    assign w_clr_mask     = bus.WB_WE_i ? (R'(1) << bus.WB_A3_i) : '0;
    assign w_pending_next = (r_pending & ~w_clr_mask) | w_set_mask;

    always_comb begin
        w_wait_next = r_wait;
        if ((w_next_state == ST_WAIT_EXE || w_next_state == ST_WAIT_MEM) &&
            (w_next_state != r_state))
            w_wait_next = '0;
        else if ((r_state == ST_WAIT_EXE || r_state == ST_WAIT_MEM) && (r_wait != '1))
            w_wait_next = r_wait + 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_RUN;
            r_pending  <= '0;
            r_wait     <= '0;
            r_mem_flag <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_pending_next;
            r_wait    <= w_wait_next;
            if (w_issue)
                r_mem_flag <= bus.mem_op_i;
        end
    end

    // Reset forces a plain pass-through pipe regardless of current inputs
    assign bus.stall_IF_o     = w_stall & ~RST;
    assign bus.enable_ID_EX_o = w_enable | RST;
    assign bus.bubble_o       = w_bubble & ~RST;
    assign bus.issue_o        = w_issue & ~RST;
    assign bus.state_o        = r_state;
    assign bus.pending_o      = r_pending;
    assign bus.wait_cycles_o  = r_wait;
endmodule

// File: tb/tb_decode_hazard_controller.sv
// Directed bench for decode_hazard_controller: hazards, scoreboard set/clear,
// wait FSM sequencing, wait counter saturation and asynchronous reset.
module tb_decode_hazard_controller;
    localparam int R  = 32;
    localparam int AW = 5;

    logic CLK;
    logic RST;
    int   n_checks;
    int   n_errors;
    logic [R-1:0] exp_q[$];

    decode_hazard_controller_if #(.R(R), .AW(AW), .CW(8)) b0 ();
    decode_hazard_controller_if #(.R(R), .AW(AW), .CW(3)) b1 ();

    decode_hazard_controller #(.R(R), .AW(AW), .CW(8)) u_dut (
        .CLK (CLK),
        .RST (RST),
        .bus (b0.slave)
    );

    decode_hazard_controller #(.R(R), .AW(AW), .CW(3)) u_dut_cw3 (
        .CLK (CLK),
        .RST (RST),
        .bus (b1.slave)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        b0.issue_valid_i  = 1'b0;
        b0.A1_i           = '0;
        b0.A2_i           = '0;
        b0.A3_i           = '0;
        b0.uses_A1_i      = 1'b0;
        b0.uses_A2_i      = 1'b0;
        b0.writes_A3_i    = 1'b0;
        b0.multicycle_i   = 1'b0;
        b0.mem_op_i       = 1'b0;
        b0.Exe_Finished_i = 1'b0;
        b0.Mem_Finished_i = 1'b0;
        b0.WB_WE_i        = 1'b0;
        b0.WB_A3_i        = '0;
    endtask

    task automatic set_op(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [AW-1:0] a3, input logic u1, input logic u2,
                          input logic w3, input logic mc, input logic mem);
        b0.issue_valid_i = 1'b1;
        b0.A1_i          = a1;
        b0.A2_i          = a2;
        b0.A3_i          = a3;
        b0.uses_A1_i     = u1;
        b0.uses_A2_i     = u2;
        b0.writes_A3_i   = w3;
        b0.multicycle_i  = mc;
        b0.mem_op_i      = mem;
    endtask

    task automatic idle_b1();
        b1.issue_valid_i  = 1'b0;
        b1.A1_i           = '0;
        b1.A2_i           = '0;
        b1.A3_i           = '0;
        b1.uses_A1_i      = 1'b0;
        b1.uses_A2_i      = 1'b0;
        b1.writes_A3_i    = 1'b0;
        b1.multicycle_i   = 1'b0;
        b1.mem_op_i       = 1'b0;
        b1.Exe_Finished_i = 1'b0;
        b1.Mem_Finished_i = 1'b0;
        b1.WB_WE_i        = 1'b0;
        b1.WB_A3_i        = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        idle_b1();
        RST = 1'b1;
        #12;
        check("rst_state",   32'(b0.state_o), 0);
        check("rst_pending", 32'(b0.pending_o), 0);
        check("rst_wait",    32'(b0.wait_cycles_o), 0);
        check("rst_stall",   32'(b0.stall_IF_o), 0);
        check("rst_enable",  32'(b0.enable_ID_EX_o), 1);
        RST = 1'b0;
        step();

        // RAW hazard on r5, resolved by writeback
        set_op(5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("raw_first_issue", 32'(b0.issue_o), 1);
        step();
        check("raw_pending5", 32'(b0.pending_o), 32'h20);
        set_op(5'd5, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        settle();
        check("raw_stall",  32'(b0.stall_IF_o), 1);
        check("raw_bubble", 32'(b0.bubble_o), 1);
        check("raw_issue0", 32'(b0.issue_o), 0);
        step();
        check("raw_state_hazard", 32'(b0.state_o), 1);
        b0.WB_WE_i = 1'b1;
        b0.WB_A3_i = 5'd5;
        settle();
        check("raw_no_wb_bypass", 32'(b0.stall_IF_o), 1);
        step();
        b0.WB_WE_i = 1'b0;
        settle();
        check("raw_resolved_issue", 32'(b0.issue_o), 1);
        check("raw_resolved_stall", 32'(b0.stall_IF_o), 0);
        check("raw_pending_clr",    32'(b0.pending_o), 0);
        step();
        check("raw_back_to_run", 32'(b0.state_o), 0);
        idle();

        // Back-to-back independent ops
        set_op(5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(32'h8);
        settle();
        check("b2b_issue1", 32'(b0.issue_o), 1);
        check("b2b_stall1", 32'(b0.stall_IF_o), 0);
        step();
        check("b2b_pending1", 32'(b0.pending_o), exp_q.pop_front());
        set_op(5'd4, 5'd6, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(32'h108);
        settle();
        check("b2b_issue2", 32'(b0.issue_o), 1);
        check("b2b_stall2", 32'(b0.stall_IF_o), 0);
        step();
        check("b2b_pending2", 32'(b0.pending_o), exp_q.pop_front());
        idle();
        b0.WB_WE_i = 1'b1;
        b0.WB_A3_i = 5'd3;
        step();
        b0.WB_A3_i = 5'd8;
        step();
        b0.WB_WE_i = 1'b0;
        check("b2b_cleared", 32'(b0.pending_o), 0);

        // Vector op with memory phase
        set_op(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        settle();
        check("vec_issue", 32'(b0.issue_o), 1);
        step();
        idle();
        settle();
        check("vec_state_exe", 32'(b0.state_o), 2);
        check("vec_enable0",   32'(b0.enable_ID_EX_o), 0);
        check("vec_stall",     32'(b0.stall_IF_o), 1);
        check("vec_bubble0",   32'(b0.bubble_o), 0);
        check("vec_wait0",     32'(b0.wait_cycles_o), 0);
        for (int i = 0; i < 3; i++) step();
        check("vec_wait3", 32'(b0.wait_cycles_o), 3);
        b0.Exe_Finished_i = 1'b1;
        step();
        b0.Exe_Finished_i = 1'b0;
        settle();
        check("vec_state_mem",  32'(b0.state_o), 3);
        check("vec_wait_restart", 32'(b0.wait_cycles_o), 0);
        check("vec_mem_bubble", 32'(b0.bubble_o), 1);
        check("vec_mem_enable", 32'(b0.enable_ID_EX_o), 1);
        step();
        b0.Mem_Finished_i = 1'b1;
        step();
        b0.Mem_Finished_i = 1'b0;
        check("vec_state_run", 32'(b0.state_o), 0);
        check("vec_wait_final", 32'(b0.wait_cycles_o), 2);
        b0.Mem_Finished_i = 1'b1;
        b0.Exe_Finished_i = 1'b1;
        step();
        idle();
        check("run_ignores_finish", 32'(b0.state_o), 0);
        check("run_wait_holds", 32'(b0.wait_cycles_o), 2);

        // Exe and Mem finish together with mem flag latched
        set_op(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        idle();
        b0.Exe_Finished_i = 1'b1;
        b0.Mem_Finished_i = 1'b1;
        step();
        idle();
        check("both_finish_run",  32'(b0.state_o), 0);
        check("both_finish_wait", 32'(b0.wait_cycles_o), 1);

        // Execute-only vector op
        set_op(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        idle();
        b0.Exe_Finished_i = 1'b1;
        step();
        idle();
        check("exe_only_run", 32'(b0.state_o), 0);

        // Set wins over same-cycle clear; clear of a clear bit is harmless
        set_op(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        b0.WB_WE_i = 1'b1;
        b0.WB_A3_i = 5'd9;
        step();
        idle();
        check("set_wins", 32'(b0.pending_o), 32'h200);
        b0.WB_WE_i = 1'b1;
        b0.WB_A3_i = 5'd4;
        step();
        idle();
        check("clear_clear_bit", 32'(b0.pending_o), 32'h200);
        set_op(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        check("waw_stall", 32'(b0.stall_IF_o), 1);
        idle();
        b0.WB_WE_i = 1'b1;
        b0.WB_A3_i = 5'd9;
        step();
        idle();

        // Asynchronous reset mid WAIT_EXE with r7 pending
        set_op(5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        idle();
        check("pre_rst_state",   32'(b0.state_o), 2);
        check("pre_rst_pending", 32'(b0.pending_o), 32'h80);
        #2;
        RST = 1'b1;
        b0.issue_valid_i = 1'b1;
        settle();
        check("mid_rst_state",   32'(b0.state_o), 0);
        check("mid_rst_pending", 32'(b0.pending_o), 0);
        check("mid_rst_stall",   32'(b0.stall_IF_o), 0);
        check("mid_rst_enable",  32'(b0.enable_ID_EX_o), 1);
        check("mid_rst_issue",   32'(b0.issue_o), 0);
        idle();
        step();
        RST = 1'b0;
        step();

        // Wait counter saturation on the CW=3 instance
        b1.issue_valid_i = 1'b1;
        b1.multicycle_i  = 1'b1;
        step();
        idle_b1();
        for (int i = 0; i < 6; i++) step();
        check("sat_wait6", 32'(b1.wait_cycles_o), 6);
        for (int i = 0; i < 4; i++) step();
        check("sat_wait10", 32'(b1.wait_cycles_o), 7);
        check("sat_state",  32'(b1.state_o), 2);
        b1.Exe_Finished_i = 1'b1;
        step();
        idle_b1();
        check("sat_exit_run", 32'(b1.state_o), 0);
        check("sat_exit_wait", 32'(b1.wait_cycles_o), 7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
